// File: rtl/unified_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Consumed by unified_mem_arbiter and mem_arb_pick.
package unified_mem_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 3;

    function automatic logic rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker between fetch and data requests.
// Fixed data-over-fetch priority, or round-robin when UNIFIED_MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import unified_mem_pkg::*;
(
`ifdef UNIFIED_MEM_ARB_RR_EN
    input  logic       i_last_win,
`endif
    input  logic       i_req_f,
    input  logic       i_req_d,
    output logic       o_win,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_win = PORT_I;
`ifdef UNIFIED_MEM_ARB_RR_EN
        // On a tie the port that lost the previous grant goes first.
        if (i_req_f && i_req_d) begin
            o_win = ~i_last_win;
        end else if (i_req_d) begin
            o_win = PORT_D;
        end
`else
        if (i_req_d) begin
            o_win = PORT_D;
        end
`endif
        o_gnt         = 2'b00;
        o_gnt[PORT_I] = (i_req_f || i_req_d) && (o_win == PORT_I);
        o_gnt[PORT_D] = (i_req_f || i_req_d) && (o_win == PORT_D);
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified single-port RAM front-end shared by instruction fetch and data access.
// Optional round-robin arbitration: define UNIFIED_MEM_ARB_RR_EN.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | arbitrate; winner's gnt is combinational, RAM regs loaded
//   ST_ACCESS | RAM busy; latency down-counter runs to terminal count 0
module unified_mem_arbiter
    import unified_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_valid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    if (!rd_lat_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("unified_mem_arbiter: RD_LATENCY must be within 1..4");
    end

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_port;
    logic                    r_we;
    logic                    r_i_valid;
    logic                    r_d_valid;
    logic [DATA_WIDTH-1:0]   r_i_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic                    r_mem_wren;

    logic                    w_arb_en;
    logic                    w_win;
    logic [1:0]              w_pick_gnt;
    logic                    w_any_gnt;
    logic                    w_win_we;
    logic                    w_done;

`ifdef UNIFIED_MEM_ARB_RR_EN
    logic r_last_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_win <= PORT_I;
        end else if (w_any_gnt) begin
            r_last_win <= w_win;
        end
    end
`endif

    mem_arb_pick u_pick (
`ifdef UNIFIED_MEM_ARB_RR_EN
        .i_last_win (r_last_win),
`endif
        .i_req_f    (i_req),
        .i_req_d    (d_req),
        .o_win      (w_win),
        .o_gnt      (w_pick_gnt)
    );

    // Grants are suppressed while reset is held so every output reads 0.
    assign w_arb_en  = (r_state == ST_IDLE) && reset;
    assign i_gnt     = w_arb_en && w_pick_gnt[PORT_I];
    assign d_gnt     = w_arb_en && w_pick_gnt[PORT_D];
    assign w_any_gnt = i_gnt || d_gnt;
    assign w_win_we  = (w_win == PORT_D) && d_we;
    assign w_done    = (r_state == ST_ACCESS) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_any_gnt) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done)    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_port        <= PORT_I;
            r_we          <= 1'b0;
            r_i_valid     <= 1'b0;
            r_d_valid     <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
        end else begin
            r_i_valid  <= w_done && (r_port == PORT_I);
            r_d_valid  <= w_done && (r_port == PORT_D);
            r_mem_wren <= w_any_gnt && w_win_we;

            if (w_done && !r_we) begin
                if (r_port == PORT_I) begin
                    r_i_rdata <= mem_q;
                end else begin
                    r_d_rdata <= mem_q;
                end
            end

            // Writes complete after one ACCESS cycle, reads after RD_LATENCY+1.
            if (w_any_gnt) begin
                r_mem_address <= (w_win == PORT_D) ? d_addr : i_addr;
                r_port        <= w_win;
                r_we          <= w_win_we;
                r_cnt         <= w_win_we ? '0 : LAT_LOAD;
                if (w_win_we) begin
                    r_mem_data <= d_wdata;
                end
            end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign i_valid     = r_i_valid;
    assign d_valid     = r_d_valid;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_wren    = r_mem_wren;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// transaction-level reference model driven by random requests.
module tb_unified_mem_arbiter;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_valid;
    logic [11:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_valid;
    logic [11:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [11:0] mem_address;
    logic [31:0] mem_data, mem_q;
    logic        mem_wren, busy;
    logic        ram_init;

    int n_tests = 0;
    int n_fail  = 0;

    unified_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(RDL)) dut (
        .clock(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [11:0] a);
        return {4'hA, a, ~a, 4'h5};
    endfunction

    // Synchronous single-port RAM with RDL cycles from registered address to q.
    logic [31:0] ram  [0:4095];
    logic [31:0] pipe [0:RDL-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 4096; k++) ram[k] <= init_word(12'(k));
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        pipe[0] <= ram[mem_address];
        for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_q = pipe[RDL-1];

    // Reference state
    logic [31:0] mdl [0:4095];
    logic [31:0] exp_rd [2];
    int          tb_last;
    int          gq[$];
`ifdef UNIFIED_MEM_ARB_RR_EN
    int exp_seq [5] = '{1, 0, 1, 0, 1};
`else
    int exp_seq [5] = '{1, 1, 1, 1, 0};
`endif

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Cycle-level model: grants per arbitration rule, valid at grant+2 (write)
    // or grant+RDL+2 (read), read data = memory contents at grant time.
    task automatic run_model(input int n_cyc, input int mode);
        int          pst [2];
        logic [11:0] p_addr [2];
        logic        p_we [2];
        logic [31:0] p_wd [2];
        int          vcyc [2];
        bit          vpend [2];
        bit          vwr [2];
        logic [31:0] vexp [2];
        int          free_at, g_c, wr_c, w, last_c;
        bit          g_we, rq_i, rq_d, any_g, ev;
        logic [11:0] g_addr;
        free_at = 0; g_c = -100; wr_c = -100; g_we = 0; g_addr = '0;
        last_c = n_cyc + 2 * (RDL + 2) + 6;
        for (int p = 0; p < 2; p++) begin
            pst[p] = 0; vpend[p] = 0; vwr[p] = 0; vcyc[p] = 0; vexp[p] = '0;
            p_addr[p] = '0; p_we[p] = 0; p_wd[p] = '0;
        end
        gq.delete();
        for (int c = 0; c < last_c; c++) begin
            bit issue;
            issue = (c < n_cyc);
            cyc_start();
            for (int p = 0; p < 2; p++) begin
                if (pst[p] == 2 && vcyc[p] == c) pst[p] = 0;
                if (pst[p] == 1 && mode == 0 && (!issue || $urandom_range(0, 9) == 0)) pst[p] = 0;
                if (pst[p] == 0 && issue && (mode == 1 || $urandom_range(0, 2) == 0)) begin
                    pst[p]    = 1;
                    p_addr[p] = (mode == 1) ? ((p == 1) ? 12'h100 : 12'h020) : 12'($urandom_range(0, 15));
                    p_we[p]   = (p == 1) && (mode == 0) && ($urandom_range(0, 1) == 1);
                    p_wd[p]   = $urandom;
                end else if (pst[p] == 2) begin
                    p_addr[p] = 12'($urandom);
                    p_wd[p]   = $urandom;
                    p_we[p]   = (p == 1) && ($urandom_range(0, 1) == 1);
                end
            end
            i_req = (pst[0] != 0); i_addr = p_addr[0];
            d_req = (pst[1] != 0); d_we = p_we[1]; d_addr = p_addr[1]; d_wdata = p_wd[1];
            samp();
            for (int p = 0; p < 2; p++) begin
                ev = vpend[p] && (vcyc[p] == c);
                if (p == 0) chk("rnd_ivalid", i_valid, ev);
                else        chk("rnd_dvalid", d_valid, ev);
                if (ev) begin
                    vpend[p] = 0;
                    if (!vwr[p]) exp_rd[p] = vexp[p];
                end
            end
            chk("rnd_irdata", i_rdata, exp_rd[0]);
            chk("rnd_drdata", d_rdata, exp_rd[1]);
            rq_i  = (pst[0] == 1);
            rq_d  = (pst[1] == 1);
            any_g = (c >= free_at) && (rq_i || rq_d);
`ifdef UNIFIED_MEM_ARB_RR_EN
            w = (rq_i && rq_d) ? (1 - tb_last) : (rq_d ? 1 : 0);
`else
            w = rq_d ? 1 : 0;
`endif
            chk("rnd_ignt", i_gnt, any_g && (w == 0));
            chk("rnd_dgnt", d_gnt, any_g && (w == 1));
            chk("rnd_busy", busy, (c > g_c) && (c < free_at));
            chk("rnd_wren", mem_wren, c == wr_c + 1);
            if (c > g_c && c <= g_c + (g_we ? 1 : RDL)) chk("rnd_maddr", mem_address, g_addr);
            if (any_g) begin
                g_c = c; g_addr = p_addr[w]; g_we = p_we[w];
                gq.push_back(w);
                if (g_we) begin
                    mdl[g_addr] = p_wd[w]; wr_c = c; vcyc[w] = c + 2; vwr[w] = 1;
                end else begin
                    vexp[w] = mdl[g_addr]; vcyc[w] = c + RDL + 2; vwr[w] = 0;
                end
                vpend[w] = 1; pst[w] = 2; free_at = vcyc[w]; tb_last = w;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        for (int k = 0; k < 4096; k++) mdl[k] = init_word(12'(k));
        exp_rd[0] = '0; exp_rd[1] = '0; tb_last = 0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        rst_n = 0; ram_init = 1;

        // Reset state, requests held high to show grants are masked
        cyc_start(); cyc_start();
        ram_init = 0; i_req = 1; d_req = 1;
        samp();
        chk("rst_gnt", {i_gnt, d_gnt}, 2'b00);
        chk("rst_valid", {i_valid, d_valid, mem_wren, busy}, 4'b0000);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        chk("rst_mem", {mem_address, mem_data}, 44'h0);
        i_req = 0; d_req = 0;
        cyc_start(); rst_n = 1;
        samp();
        chk("rst_rel_busy", busy, 1'b0);

        // Both ports hold read requests continuously
        run_model(3 * (RDL + 2) + 1, 1);
        chk("arb_seq_len", gq.size(), 5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("arb_seq", gq[k], exp_seq[k]);

        // Store 0x8C010000 to 0x004
        cyc_start(); d_req = 1; d_we = 1; d_addr = 12'h004; d_wdata = 32'h8C010000;
        samp(); chk("st4_gnt", {i_gnt, d_gnt}, 2'b01);
        cyc_start(); samp();
        chk("st4_wren", mem_wren, 1'b1);
        chk("st4_addr", mem_address, 12'h004);
        chk("st4_data", mem_data, 32'h8C010000);
        chk("st4_busy", busy, 1'b1);
        cyc_start(); d_req = 0; d_we = 0; samp();
        chk("st4_valid", d_valid, 1'b1);
        chk("st4_wren0", mem_wren, 1'b0);
        chk("st4_idle", busy, 1'b0);
        mdl[12'h004] = 32'h8C010000;

        // Fetch read of 0x004
        cyc_start(); i_req = 1; i_addr = 12'h004; samp();
        chk("f4_gnt", {i_gnt, d_gnt}, 2'b10);
        for (int k = 1; k <= RDL; k++) begin
            cyc_start(); samp();
            chk("f4_addr_hold", mem_address, 12'h004);
            chk("f4_novalid", i_valid, 1'b0);
        end
        cyc_start(); samp();
        chk("f4_pre_valid", {i_valid, busy}, 2'b01);
        cyc_start(); i_req = 0; samp();
        chk("f4_valid", i_valid, 1'b1);
        chk("f4_rdata", i_rdata, 32'h8C010000);
        chk("f4_busy", busy, 1'b0);
        cyc_start(); samp();
        chk("f4_pulse", i_valid, 1'b0);
        chk("f4_hold", i_rdata, 32'h8C010000);

        // Store to 0xFFF then back-to-back load of 0xFFF
        cyc_start(); d_req = 1; d_we = 1; d_addr = 12'hFFF; d_wdata = 32'hDEADBEEF;
        samp(); chk("sl_gnt_w", d_gnt, 1'b1);
        cyc_start(); samp();
        chk("sl_wren", mem_wren, 1'b1);
        chk("sl_addr", mem_address, 12'hFFF);
        chk("sl_data", mem_data, 32'hDEADBEEF);
        chk("sl_nognt", d_gnt, 1'b0);
        cyc_start(); d_we = 0; d_wdata = '0; samp();
        chk("sl_wvalid", d_valid, 1'b1);
        chk("sl_gnt_r", d_gnt, 1'b1);
        chk("sl_wren_drop", mem_wren, 1'b0);
        for (int k = 1; k <= RDL + 1; k++) begin
            cyc_start(); samp();
            chk("sl_wait", {d_valid, mem_wren}, 2'b00);
        end
        cyc_start(); d_req = 0; samp();
        chk("sl_rvalid", d_valid, 1'b1);
        chk("sl_rdata", d_rdata, 32'hDEADBEEF);
        mdl[12'hFFF] = 32'hDEADBEEF;

        // Fetch request raised for one cycle during a data read, then withdrawn
        cyc_start(); d_req = 1; d_we = 0; d_addr = 12'h100; samp();
        chk("wd_dgnt", d_gnt, 1'b1);
        for (int k = 1; k <= RDL + 4; k++) begin
            cyc_start();
            i_req = (k == 1); i_addr = 12'h030;
            if (k == RDL + 2) d_req = 0;
            samp();
            chk("wd_ignt", {i_gnt, i_valid}, 2'b00);
            chk("wd_addr", mem_address, 12'h100);
            chk("wd_dvalid", d_valid, k == RDL + 2);
            if (k == RDL + 2) chk("wd_rdata", d_rdata, mdl[12'h100]);
        end

        // Data request dropped right after its grant still completes once
        cyc_start(); d_req = 1; d_addr = 12'h0AB; samp();
        chk("dr_gnt", d_gnt, 1'b1);
        nv = 0;
        for (int k = 1; k <= RDL + 5; k++) begin
            cyc_start(); d_req = 0; d_addr = 12'($urandom); samp();
            nv += int'(d_valid);
        end
        chk("dr_nvalid", nv, 1);
        chk("dr_rdata", d_rdata, mdl[12'h0AB]);

        // Random traffic against the reference model
        exp_rd[0] = 32'h8C010000; exp_rd[1] = mdl[12'h0AB]; tb_last = 1;
        run_model(400, 0);

        // Reset in the middle of a fetch read of 0x010
        cyc_start(); i_req = 1; i_addr = 12'h010; samp();
        chk("rm_gnt", i_gnt, 1'b1);
        cyc_start(); rst_n = 0; #1;
        chk("rm_gnt0", {i_gnt, d_gnt, i_valid, d_valid, mem_wren, busy}, 6'b0);
        chk("rm_rdata0", {i_rdata, d_rdata}, 64'h0);
        chk("rm_mem0", {mem_address, mem_data}, 44'h0);
        cyc_start(); i_req = 0;
        cyc_start(); rst_n = 1;
        for (int k = 1; k <= RDL + 3; k++) begin
            samp();
            chk("rm_after", {i_valid, busy}, 2'b00);
            cyc_start();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Single-clock memory front-end for the next-generation processor skeleton.
- Replaces the separate imem/dmem with a clock inverted relative to the processor clock by one unified synchronous single-port RAM.
- Arbitrates between an instruction-fetch port (read-only) and a data port (read/write), counts a configurable RAM read latency, and returns registered response pulses the processor uses to stall.

Parameters:
- ADDR_WIDTH, 12: word address width for both ports and the RAM.
- DATA_WIDTH, 32: data word width.
- RD_LATENCY, 1: RAM cycles from a registered address to valid mem_q. Legal range is 1..4; an elaboration error is raised otherwise.

Ports:
- clock  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_valid.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_valid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_WIDTH  fetched instruction (registered).
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_valid.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: read data valid or write complete.
- d_rdata  out  DATA_WIDTH  load data (registered).
- mem_address  out  ADDR_WIDTH  RAM address (registered).
- mem_data  out  DATA_WIDTH  RAM write data (registered).
- mem_wren  out  1  RAM write enable (registered).
- mem_q  in  DATA_WIDTH  RAM read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - reset low forces state IDLE and clears the latency counter.
  - All outputs go to 0, including rdata registers and mem_* registers.
  - An in-flight access is abandoned with no valid pulse.
  - mem_wren drops immediately, so no partial write is issued after the reset edge.
- States:
  - IDLE: arbitration.
  - ACCESS: RAM busy; 3-bit latency counter active.
- IDLE, cycle T:
  - If any request is pending, the winner's gnt is asserted combinationally in T.
  - At the end of T, mem_address/mem_data/mem_wren are registered from the winner, the port id and we are latched, and state goes to ACCESS.
  - No request pending: stay in IDLE; mem_wren is 0.
- Priority (default): d_req beats i_req when both are high in the same IDLE cycle. A load/store in flight in the pipeline must not be starved by fetch.
- Write, granted in T:
  - mem_wren = 1 only in T+1.
  - d_valid pulses in T+2.
  - State returns to IDLE in T+2.
- Read, granted in T:
  - mem_address is held stable for T+1..T+RD_LATENCY.
  - mem_q is valid in T+1+RD_LATENCY and is captured into the requester's rdata at the end of that cycle.
  - The requester's valid pulses in T+2+RD_LATENCY; state is IDLE in that cycle.
  - rdata holds its value until the next read on the same port.
- Throughput:
  - A new grant may occur in the same cycle as the previous valid pulse.
  - Port occupancy is RD_LATENCY+2 cycles per read and 2 cycles per write.
- Request rules:
  - Deasserting req before its gnt cancels it; no access occurs.
  - Deasserting req after gnt does not cancel; the access completes and valid still pulses.
  - Address/data changes after gnt are ignored, because the access uses the latched values.
- gnt and valid never pulse on both ports in the same cycle.
- i_valid is never asserted for a write.
- mem_address wrap is natural; no bounds check.

Optional Feature:
- Macro: UNIFIED_MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last-winner register, reset to fetch, gives round-robin arbitration.
  - On simultaneous requests, the port that did not win the previous grant wins.
  - A lone requester always wins.
- Undefined: fixed data-over-fetch priority; the register is not instantiated.

Decomposition:
- Shared package unified_mem_pkg holds:
  - state enum (IDLE, ACCESS);
  - port-id constants PORT_I = 0, PORT_D = 1;
  - default widths 12/32;
  - RD_LATENCY bounds 1..4.
- One natural sub-module, mem_arb_pick: combinational two-way picker (fixed or round-robin) producing the winner and the gnt vector.
- The FSM, latency counter and response registers stay in the top module.

Test Plan:
- Reset mid-read: assert reset low during ACCESS of an i_req read to 0x010 -> all outputs 0 that cycle, no i_valid pulse; after release, state IDLE and busy = 0.
- Fetch read, RD_LATENCY = 2: i_req with i_addr = 0x004, RAM word 0x8C010000, i_gnt in T -> mem_address = 0x004 in T+1..T+2, i_valid with i_rdata = 0x8C010000 in T+4, busy low in T+4.
- Store then load: d_we = 1, d_addr = 0xFFF, d_wdata = 0xDEADBEEF -> mem_wren high only in T+1, d_valid in T+2; immediate read of 0xFFF granted in T+2 -> d_rdata = 0xDEADBEEF with RD_LATENCY = 1 at T+5.
- Simultaneous requests, fixed priority (i_addr = 0x020, d_addr = 0x100, both held) -> d_gnt first, i_gnt in the cycle of d_valid; repeated d_req keeps i starved.
- Same stimulus with UNIFIED_MEM_ARB_RR_EN -> grants alternate d, i, d, i.
- Request withdrawn: i_req high one cycle while state ACCESS, then low -> no i_gnt, no RAM access. Request dropped after d_gnt -> d_valid still pulses once.
